// File: rtl/gray_win_pkg.sv
// Shared constants and helpers for the 3x3 grayscale window generator.
// win_idx gives the bit offset of tap (row i, column j) in the flat window bus.
package gray_win_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_TAPS  = 9;
    localparam int WIN_W     = PIX_W * WIN_TAPS;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    function automatic int win_idx(input int i, input int j);
        return PIX_W * (3 * i + j);
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// One-line pixel store: simple dual-port RAM, registered read, read-first on
// address collision, no reset on the array or the read register.
module gray_line_buffer
    import gray_win_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/gray_win3x3_gen.sv
// 3x3 sliding window over a raster gray stream. Two-stage pipeline: stage 1
// reads both line buffers, stage 2 shifts the window and registers outputs.
module gray_win3x3_gen
    import gray_win_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] gray_in,
    input  logic             gray_in_valid,
    input  logic             gray_in_sof,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    output logic [XW-1:0]    win_x,
    output logic [YW-1:0]    win_y
);

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]    col, cur_col, nxt_col;
    logic [YW-1:0]    row, cur_row, nxt_row;

    logic             s1_valid;
    logic [PIX_W-1:0] s1_pix;
    logic [XW-1:0]    s1_col;
    logic [YW-1:0]    s1_row;

    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic [WIN_W-1:0] win_nxt;
    logic             emit;

    // sof overrides the counters for the current pixel only
    always_comb begin
        cur_col = gray_in_sof ? '0 : col;
        cur_row = gray_in_sof ? '0 : row;
        nxt_col = cur_col + XW'(1);
        nxt_row = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + YW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= gray_in_valid;
            if (gray_in_valid) begin
                col    <= nxt_col;
                row    <= nxt_row;
                s1_pix <= gray_in;
                s1_col <= cur_col;
                s1_row <= cur_row;
            end
        end
    end

    gray_line_buffer #(
        .DEPTH (IMG_W),
        .AW    (XW)
    ) u_lb0 (
        .clk     (clk),
        .rd_en   (gray_in_valid),
        .rd_addr (cur_col),
        .rd_data (lb0_q),
        .wr_en   (gray_in_valid),
        .wr_addr (cur_col),
        .wr_data (gray_in)
    );

    // lb1 takes the old lb0 entry one cycle later, once the read has landed
    gray_line_buffer #(
        .DEPTH (IMG_W),
        .AW    (XW)
    ) u_lb1 (
        .clk     (clk),
        .rd_en   (gray_in_valid),
        .rd_addr (cur_col),
        .rd_data (lb1_q),
        .wr_en   (s1_valid),
        .wr_addr (s1_col),
        .wr_data (lb0_q)
    );

    always_comb begin
        win_nxt = win;
        for (int i = 0; i < 3; i++) begin
            win_nxt[win_idx(i, 0) +: PIX_W] = win[win_idx(i, 1) +: PIX_W];
            win_nxt[win_idx(i, 1) +: PIX_W] = win[win_idx(i, 2) +: PIX_W];
        end
        win_nxt[win_idx(0, 2) +: PIX_W] = lb1_q;
        win_nxt[win_idx(1, 2) +: PIX_W] = lb0_q;
        win_nxt[win_idx(2, 2) +: PIX_W] = s1_pix;
    end

    assign emit = s1_valid && (s1_col >= XW'(2)) && (s1_row >= YW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
        end else begin
            win_valid <= emit;
            if (s1_valid) begin
                win <= win_nxt;
            end
            if (emit) begin
                win_x <= s1_col - XW'(1);
                win_y <= s1_row - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gray_win3x3_gen.sv
// Directed bench for gray_win3x3_gen on an 8x6 image with pixel = 16*y + x + base.
// Cycle records carry inputs and the window expected two cycles later.
module tb_gray_win3x3_gen;
    import gray_win_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = 4;
    localparam int YW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       gray_in = '0;
    logic             gray_in_valid = 1'b0;
    logic             gray_in_sof = 1'b0;
    logic [71:0]      win;
    logic             win_valid;
    logic [XW-1:0]    win_x;
    logic [YW-1:0]    win_y;

    always #5 clk = ~clk;

    gray_win3x3_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .XW    (XW),
        .YW    (YW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gray_in       (gray_in),
        .gray_in_valid (gray_in_valid),
        .gray_in_sof   (gray_in_sof),
        .win           (win),
        .win_valid     (win_valid),
        .win_x         (win_x),
        .win_y         (win_y)
    );

    typedef struct {
        logic          v;
        logic          s;
        logic [7:0]    p;
        logic          ev;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [71:0]   ew;
    } vec_t;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [71:0]   w;
    } wout_t;

    vec_t  vecs[$];
    wout_t got[$];
    wout_t ref_seq[$];

    int total = 0;
    int bad   = 0;
    int m_col = 0;
    int m_row = 0;
    logic [7:0] img [H][W];

    task automatic check(input string name, input logic [71:0] got_v, input logic [71:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got_v, exp_v, $time);
        end
    endtask

    task automatic add_pix(input logic v, input logic s, input int p);
        vec_t r;
        int cx, cy;
        r.v = v; r.s = s & v; r.p = p[7:0];
        r.ev = 1'b0; r.ex = '0; r.ey = '0; r.ew = '0;
        if (v) begin
            cx = s ? 0 : m_col;
            cy = s ? 0 : m_row;
            img[cy][cx] = p[7:0];
            if (cx >= 2 && cy >= 2) begin
                r.ev = 1'b1;
                r.ex = XW'(cx - 1);
                r.ey = YW'(cy - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        r.ew[8*(3*i+j) +: 8] = img[cy-2+i][cx-2+j];
            end
            m_col = cx + 1;
            m_row = cy;
            if (m_col == W) begin
                m_col = 0;
                m_row = (cy + 1) % H;
            end
        end
        vecs.push_back(r);
    endtask

    task automatic add_idle(input int n);
        repeat (n) add_pix(1'b0, 1'b0, 0);
    endtask

    task automatic add_frame(input int base, input bit first_sof, input bit gaps);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (gaps) add_idle($urandom_range(0, 2));
                add_pix(1'b1, first_sof && y == 0 && x == 0, base + 16*y + x);
            end
    endtask

    task automatic run_vecs(output int pulses);
        got.delete();
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            gray_in       = vecs[k].p;
            gray_in_valid = vecs[k].v;
            gray_in_sof   = vecs[k].s;
            @(negedge clk);
            if (win_valid === 1'b1) got.push_back('{win_x, win_y, win});
            if (k >= 2) begin
                check($sformatf("win_valid[%0d]", k-2), {71'd0, win_valid}, {71'd0, vecs[k-2].ev});
                if (vecs[k-2].ev) begin
                    check($sformatf("win_x[%0d]", k-2), {{(72-XW){1'b0}}, win_x}, {{(72-XW){1'b0}}, vecs[k-2].ex});
                    check($sformatf("win_y[%0d]", k-2), {{(72-YW){1'b0}}, win_y}, {{(72-YW){1'b0}}, vecs[k-2].ey});
                    check($sformatf("win[%0d]", k-2), win, vecs[k-2].ew);
                end
            end
        end
        vecs.delete();
        pulses = got.size();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, max_x, n_x6, minv;
        logic [71:0] first_exp;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_win", win, 72'd0);
        check("rst_valid", {71'd0, win_valid}, 72'd0);
        check("rst_x", {68'd0, win_x}, 72'd0);
        check("rst_y", {69'd0, win_y}, 72'd0);
        rst = 1'b0;

        // continuous frame
        m_col = 0; m_row = 0;
        add_frame(0, 1'b1, 1'b0);
        add_idle(2);
        run_vecs(pulses);
        check("cont_pulses", 72'(pulses), 72'd24);
        first_exp = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
        if (got.size() > 0) begin
            check("cont_first_win", got[0].w, first_exp);
            check("cont_first_x", 72'(got[0].x), 72'd1);
            check("cont_first_y", 72'(got[0].y), 72'd1);
        end
        max_x = 0; n_x6 = 0;
        foreach (got[i]) begin
            if (int'(got[i].x) > max_x) max_x = int'(got[i].x);
            if (got[i].x == 4'd6) n_x6++;
        end
        check("wrap_max_x", 72'(max_x), 72'd6);
        check("wrap_rows_end_x6", 72'(n_x6), 72'd4);
        ref_seq = got;

        // same frame with random valid gaps
        add_frame(0, 1'b1, 1'b1);
        add_idle(2);
        run_vecs(pulses);
        check("gap_pulses", 72'(pulses), 72'd24);
        for (int i = 0; i < got.size() && i < ref_seq.size(); i++) begin
            check($sformatf("gap_seq_win[%0d]", i), got[i].w, ref_seq[i].w);
            check($sformatf("gap_seq_xy[%0d]", i), 72'({got[i].x, got[i].y}), 72'({ref_seq[i].x, ref_seq[i].y}));
        end

        // two frames back to back, second offset by 100
        add_frame(0, 1'b1, 1'b0);
        add_frame(100, 1'b1, 1'b0);
        add_idle(2);
        run_vecs(pulses);
        check("two_pulses", 72'(pulses), 72'd48);
        if (got.size() > 24) begin
            check("f2_centre", 72'(got[24].w[39:32]), 72'd117);
            check("f2_xy", 72'({got[24].x, got[24].y}), 72'({4'd1, 3'd1}));
            minv = 255;
            for (int b = 0; b < 9; b++)
                if (int'(got[24].w[8*b +: 8]) < minv) minv = int'(got[24].w[8*b +: 8]);
            check("f2_no_old_vals", 72'(minv >= 100), 72'd1);
        end

        // sof at pixel index 20, then a clean frame offset by 50
        for (int idx = 0; idx < 20; idx++)
            add_pix(1'b1, idx == 0, 16*(idx/W) + idx%W);
        add_frame(50, 1'b1, 1'b0);
        add_idle(2);
        run_vecs(pulses);
        check("sof_pulses", 72'(pulses), 72'd26);
        if (got.size() > 2) begin
            check("sof_inflight0_centre", 72'(got[0].w[39:32]), 72'd17);
            check("sof_inflight1_x", 72'(got[1].x), 72'd2);
            check("sof_new_xy", 72'({got[2].x, got[2].y}), 72'({4'd1, 3'd1}));
            check("sof_new_centre", 72'(got[2].w[39:32]), 72'd67);
        end

        // reset pulsed mid-frame at row 3
        for (int idx = 0; idx < 30; idx++)
            add_pix(1'b1, idx == 0, 16*(idx/W) + idx%W);
        run_vecs(pulses);
        check("pre_rst_valid", {71'd0, win_valid}, 72'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_win", win, 72'd0);
        check("async_rst_valid", {71'd0, win_valid}, 72'd0);
        check("async_rst_x", {68'd0, win_x}, 72'd0);
        check("async_rst_y", {69'd0, win_y}, 72'd0);
        gray_in_valid = 1'b0;
        gray_in_sof   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_col = 0; m_row = 0;
        add_frame(0, 1'b0, 1'b0);
        add_idle(2);
        run_vecs(pulses);
        check("post_rst_pulses", 72'(pulses), 72'd24);
        if (got.size() > 0) begin
            check("post_rst_first_xy", 72'({got[0].x, got[0].y}), 72'({4'd1, 3'd1}));
            check("post_rst_first_centre", 72'(got[0].w[39:32]), 72'd17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
